gpio_in_debounce: RTL and testbench

// Input conditioning stage between the FPGA pad controller and the SoC mio_in_i bus.

---
 rtl/gpio_in_debounce.sv | 67 ++++++
 tb/tb_gpio_in_debounce.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/gpio_in_debounce.sv
// GPIO pad input conditioning: two-flop synchroniser followed by a per-bit counter
// debouncer, producing a clean level and a one-cycle change strobe per bit.
module gpio_in_debounce #(
    parameter int unsigned      Width          = 32,
    parameter int unsigned      DebounceCycles = 1000,
    parameter logic [Width-1:0] ResetVal       = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] pad_i,
    input  logic [Width-1:0] bypass_i,
    output logic [Width-1:0] out_o,
    output logic [Width-1:0] change_o
);

    localparam int unsigned     CntW   = $clog2(DebounceCycles + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

    for (genvar gi = 0; gi < Width; gi++) begin : g_bit
        logic            sync1_q;
        logic            sync2_q;
        logic            stable_q;
        logic            stable_d;
        logic            change_q;
        logic            change_d;
        logic [CntW-1:0] cnt_q;
        logic [CntW-1:0] cnt_d;

        // The count only advances while sync2 disagrees with the accepted level, so any
        // return to the stable level discards partial progress.
        always_comb begin
            stable_d = stable_q;
            cnt_d    = '0;
            if (bypass_i[gi]) begin
                stable_d = sync2_q;
            end else if (sync2_q != stable_q) begin
                if (cnt_q == CntMax) begin
                    stable_d = sync2_q;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            change_d = (stable_d != stable_q);
        end

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                sync1_q  <= ResetVal[gi];
                sync2_q  <= ResetVal[gi];
                stable_q <= ResetVal[gi];
                cnt_q    <= '0;
                change_q <= 1'b0;
            end else begin
                // Pure flop-to-flop path for metastability settling.
                sync1_q  <= pad_i[gi];
                sync2_q  <= sync1_q;
                stable_q <= stable_d;
                cnt_q    <= cnt_d;
                change_q <= change_d;
            end
        end

        assign out_o[gi]    = stable_q;
        assign change_o[gi] = change_q;
    end

endmodule

// File: tb/tb_gpio_in_debounce.sv
// Bench for gpio_in_debounce (Width=4, DebounceCycles=4): vector table plus hand-written
// corner sequences, with expectations routed through a scoreboard queue.
module tb_gpio_in_debounce;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic [3:0] pad_i = 4'b0000;
    logic [3:0] bypass_i = 4'b0000;
    logic [3:0] out_o;
    logic [3:0] change_o;

    gpio_in_debounce #(
        .Width(4),
        .DebounceCycles(4),
        .ResetVal(4'b0000)
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .pad_i(pad_i),
        .bypass_i(bypass_i),
        .out_o(out_o),
        .change_o(change_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       rst_n;
        logic [3:0] pad;
        logic [3:0] byp;
        logic [3:0] exp_out;
        logic [3:0] exp_chg;
        string      name;
    } vec_t;

    typedef struct {
        logic [3:0] out;
        logic [3:0] chg;
        string      name;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_step = 0;

    function automatic void add(input int n, input logic r, input logic [3:0] p,
                                input logic [3:0] b, input logic [3:0] eo,
                                input logic [3:0] ec, input string nm);
        vec_t v;
        v.rst_n = r; v.pad = p; v.byp = b; v.exp_out = eo; v.exp_chg = ec; v.name = nm;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] p, input logic [3:0] b,
                        input logic [3:0] eo, input logic [3:0] ec, input string nm);
        exp_t e;
        exp_t got;
        @(negedge clk_i);
        rst_ni = r;
        pad_i = p;
        bypass_i = b;
        e.out = eo; e.chg = ec; e.name = nm;
        sb.push_back(e);
        @(posedge clk_i);
        #1;
        got = sb.pop_front();
        $display("step %0d %s rst_n=%b pad=%b byp=%b out=%b chg=%b", n_step, got.name,
                 r, p, b, out_o, change_o);
        n_step++;
        check({got.name, ".out"}, {28'd0, out_o}, {28'd0, got.out});
        check({got.name, ".chg"}, {28'd0, change_o}, {28'd0, got.chg});
    endtask

    initial begin
        int n;

        // reset and idle
        add(2, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "reset");
        add(10, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "idle");
        // bit0 rise: accepted after edge k+5
        add(5, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, "b0_wait");
        add(1, 1, 4'b0001, 4'b0000, 4'b0001, 4'b0001, "b0_rise");
        add(1, 1, 4'b0001, 4'b0000, 4'b0001, 4'b0000, "b0_strobe_end");
        // bit1 three-cycle glitch is rejected
        add(3, 1, 4'b0011, 4'b0000, 4'b0001, 4'b0000, "b1_glitch");
        add(6, 1, 4'b0001, 4'b0000, 4'b0001, 4'b0000, "b1_after");
        // bit2 chatter 1,1,1,0,1,1,1,1 then held
        add(3, 1, 4'b0101, 4'b0000, 4'b0001, 4'b0000, "b2_chatter_hi");
        add(1, 1, 4'b0001, 4'b0000, 4'b0001, 4'b0000, "b2_chatter_lo");
        add(5, 1, 4'b0101, 4'b0000, 4'b0001, 4'b0000, "b2_requalify");
        add(1, 1, 4'b0101, 4'b0000, 4'b0101, 4'b0100, "b2_rise");
        add(1, 1, 4'b0101, 4'b0000, 4'b0101, 4'b0000, "b2_strobe_end");
        // bit3 bypass: visible after edge k+2, no strobe when bypass drops
        add(1, 1, 4'b0101, 4'b1000, 4'b0101, 4'b0000, "b3_byp_on");
        add(2, 1, 4'b1101, 4'b1000, 4'b0101, 4'b0000, "b3_byp_wait");
        add(1, 1, 4'b1101, 4'b1000, 4'b1101, 4'b1000, "b3_byp_rise");
        add(1, 1, 4'b1101, 4'b1000, 4'b1101, 4'b0000, "b3_byp_strobe_end");
        add(6, 1, 4'b1101, 4'b0000, 4'b1101, 4'b0000, "b3_byp_off");
        // reset mid-count, then re-qualify after release
        add(1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "rst_clear");
        add(4, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, "pre_rst_count");
        add(2, 0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, "rst_mid");
        add(5, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, "post_rst_wait");
        add(1, 1, 4'b1111, 4'b0000, 4'b1111, 4'b1111, "post_rst_rise");
        add(1, 1, 4'b1111, 4'b0000, 4'b1111, 4'b0000, "post_rst_hold");

        foreach (vecs[i])
            step(vecs[i].rst_n, vecs[i].pad, vecs[i].byp, vecs[i].exp_out,
                 vecs[i].exp_chg, vecs[i].name);

        // all bits fall together: strobe expected on the 6th edge after the pad change
        @(negedge clk_i);
        pad_i = 4'b0000;
        n = 0;
        while (n < 20) begin
            @(posedge clk_i);
            #1;
            n++;
            if (change_o != 4'b0000) break;
        end
        $display("fall: strobe after %0d edges out=%b chg=%b", n, out_o, change_o);
        check("fall_latency_edges", n, 6);
        check("fall_out", {28'd0, out_o}, 32'd0);
        check("fall_chg", {28'd0, change_o}, 32'hF);
        @(posedge clk_i);
        #1;
        $display("fall: next cycle out=%b chg=%b", out_o, change_o);
        check("fall_chg_end", {28'd0, change_o}, 32'd0);

        // exactly DebounceCycles high is accepted, then the fall is debounced too
        for (int i = 0; i < 4; i++)
            step(1, 4'b0010, 4'b0000, 4'b0000, 4'b0000, "b1_exact_hi");
        step(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "b1_exact_wait");
        step(1, 4'b0000, 4'b0000, 4'b0010, 4'b0010, "b1_exact_rise");
        for (int i = 0; i < 3; i++)
            step(1, 4'b0000, 4'b0000, 4'b0010, 4'b0000, "b1_exact_hold");
        step(1, 4'b0000, 4'b0000, 4'b0000, 4'b0010, "b1_exact_fall");
        step(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "b1_exact_idle");

        check("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
